// File: rtl/div_pkg.sv
// Shared types for the iterative divider: opcode and FSM state encodings,
// plus opcode-decoding helpers.
package div_pkg;

   typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;

   typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;

   localparam int XLEN_DEF = 32;
   localparam int CNT_W    = $clog2(XLEN_DEF + 1);

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift {rem,quo} left by one bit,
// then subtract the divisor if it fits and record a quotient bit.
module div_restore_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_nxt,
   output logic [XLEN-1:0] quo_nxt
);

   logic [XLEN:0] shifted;
   logic          ge;

   assign shifted = {rem, quo[XLEN-1]};
   assign ge      = shifted >= {1'b0, divisor};
   // The true difference is always below 2^XLEN, so the low bits are exact.
   assign rem_nxt = shifted[XLEN-1:0] - (ge ? divisor : '0);
   assign quo_nxt = {quo[XLEN-2:0], ge};

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU; one quotient bit per
// clock, with optional two-cycle completion for divide-by-zero and overflow.
//
//   state | meaning
//   IDLE  | waiting for start; result_divide holds the last result
//   CALC  | one restoring step per clock, XLEN steps total
//   FIX   | apply signs, register the result, pulse done next cycle
module divider_iterative
   import div_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter bit FASTPATH = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      div_opcode,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic [XLEN-1:0] result_divide,
   output logic            done,
   output logic            stall
);

   localparam int CW = $clog2(XLEN + 1);

   div_state_e      state, state_nxt;
   div_op_e         op_in, op_q;
   logic            sign1_q, sign2_q, dz_q;
   logic [XLEN-1:0] dvsr_q, rem_q, quo_q, rem_step, quo_step;
   logic [XLEN-1:0] abs1, abs2, quo_fix, rem_fix, result_nxt;
   logic [CW-1:0]   cnt_q;
   logic            neg1, neg2, div_zero, ovf, special, accept;

   assign op_in    = div_op_e'(div_opcode);
   assign neg1     = op_is_signed(op_in) & operand1[XLEN-1];
   assign neg2     = op_is_signed(op_in) & operand2[XLEN-1];
   assign abs1     = neg1 ? -operand1 : operand1;
   assign abs2     = neg2 ? -operand2 : operand2;
   assign div_zero = (operand2 == '0);
   assign ovf      = op_is_signed(op_in) && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (operand2 == '1);
   assign special  = FASTPATH && (div_zero || ovf);
   assign accept   = (state == IDLE) && start && !flush;

   assign stall = start | (state != IDLE);

   div_restore_step #(.XLEN(XLEN)) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dvsr_q),
      .rem_nxt (rem_step),
      .quo_nxt (quo_step)
   );

   // A zero divisor yields all-ones regardless of operand signs.
   assign quo_fix    = ((sign1_q ^ sign2_q) && !dz_q) ? -quo_q : quo_q;
   assign rem_fix    = sign1_q ? -rem_q : rem_q;
   assign result_nxt = op_is_rem(op_q) ? rem_fix : quo_fix;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? FIX : CALC;
         CALC: begin
            if (flush)                   state_nxt = IDLE;
            else if (cnt_q == CW'(1))    state_nxt = FIX;
         end
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt_q         <= '0;
         result_divide <= '0;
         done          <= 1'b0;
         op_q          <= DIV;
         sign1_q       <= 1'b0;
         sign2_q       <= 1'b0;
         dz_q          <= 1'b0;
         dvsr_q        <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
      end else begin
         state <= state_nxt;
         done  <= (state == FIX) && !flush;
         if (accept) begin
            op_q    <= op_in;
            sign1_q <= neg1;
            sign2_q <= neg2;
            dz_q    <= div_zero;
            dvsr_q  <= abs2;
            cnt_q   <= CW'(XLEN);
            // Fast path preloads exactly what the full iteration would produce.
            if (special) begin
               quo_q <= div_zero ? '1 : abs1;
               rem_q <= div_zero ? abs1 : '0;
            end else begin
               quo_q <= abs1;
               rem_q <= '0;
            end
         end else if (state == CALC) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - 1'b1;
         end
         if ((state == FIX) && !flush) result_divide <= result_nxt;
      end
   end

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench: a FASTPATH=1 and a FASTPATH=0 divider share stimulus
// and are compared against an arithmetic reference model.
module tb_divider_iterative;
   import div_pkg::*;

   localparam logic [31:0] MIN = 32'h8000_0000;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  div_opcode;
   logic [31:0] operand1, operand2;
   logic [31:0] res_f, res_s;
   logic        done_f, done_s, stall_f, stall_s;
   int          n_err = 0;
   int          n_chk = 0;
   logic [31:0] last_res;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   divider_iterative #(.XLEN(32), .FASTPATH(1'b1)) u_fast (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .div_opcode(div_opcode),
      .operand1(operand1), .operand2(operand2), .result_divide(res_f),
      .done(done_f), .stall(stall_f)
   );

   divider_iterative #(.XLEN(32), .FASTPATH(1'b0)) u_slow (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .div_opcode(div_opcode),
      .operand1(operand1), .operand2(operand2), .result_divide(res_s),
      .done(done_s), .stall(stall_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else if (!op[0] && a == MIN && b == '1) begin
         q = MIN;
         r = 32'd0;
      end else if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == MIN && b == '1);
   endfunction

   function automatic vec_t mk(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input bit sp);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.special = sp;
      return v;
   endfunction

   // Issue one op on both DUTs and check value, latency and single done pulse.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit sp);
      int lat_f, lat_s, nd_f, nd_s;
      logic [31:0] r_f, r_s;
      lat_f = 0; lat_s = 0; nd_f = 0; nd_s = 0; r_f = 'x; r_s = 'x;
      div_opcode = op; operand1 = a; operand2 = b; start = 1'b1;
      #1;
      check($sformatf("%s stall_on_start", name), 32'(stall_f), 32'd1);
      tick();
      start = 1'b0;
      for (int n = 2; n <= 40; n++) begin
         tick();
         if (done_f) begin nd_f++; lat_f = n; r_f = res_f; end
         if (done_s) begin nd_s++; lat_s = n; r_s = res_s; end
         if (n == 33) check($sformatf("%s stall_busy", name), 32'(stall_s), 32'd1);
         if (n == 34) check($sformatf("%s stall_at_done", name), 32'(stall_s), 32'd0);
      end
      check($sformatf("%s res_fast", name), r_f, exp);
      check($sformatf("%s res_slow", name), r_s, exp);
      check($sformatf("%s lat_fast", name), lat_f, sp ? 32'd2 : 32'd34);
      check($sformatf("%s lat_slow", name), lat_s, 32'd34);
      check($sformatf("%s ndone_fast", name), nd_f, 32'd1);
      check($sformatf("%s ndone_slow", name), nd_s, 32'd1);
      last_res = exp;
   endtask

   task automatic expect_no_done(input string name, input int cycles);
      int nd;
      nd = 0;
      for (int n = 0; n < cycles; n++) begin
         tick();
         if (done_f || done_s) nd++;
      end
      check($sformatf("%s no_done", name), nd, 32'd0);
      check($sformatf("%s idle", name), {30'd0, stall_f, stall_s}, 32'd0);
      check($sformatf("%s held_fast", name), res_f, last_res);
      check($sformatf("%s held_slow", name), res_s, last_res);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          nd, lat;
      logic [31:0] r;

      rst = 1'b0; start = 1'b0; flush = 1'b0;
      div_opcode = 2'b00; operand1 = '0; operand2 = '0;
      last_res = '0;
      #3;
      check("reset result", res_f, 32'd0);
      check("reset done", {31'd0, done_f | done_s}, 32'd0);
      check("reset stall", {30'd0, stall_f, stall_s}, 32'd0);
      start = 1'b1;
      #1;
      check("reset stall_eq_start", 32'(stall_s), 32'd1);
      start = 1'b0;
      #18;
      rst = 1'b1;
      tick();

      vecs.push_back(mk("divu_100_7",  DIVU, 32'd100, 32'd7, 32'd14, 1'b0));
      vecs.push_back(mk("remu_100_7",  REMU, 32'd100, 32'd7, 32'd2, 1'b0));
      vecs.push_back(mk("div_m7_2",    DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0));
      vecs.push_back(mk("rem_m7_2",    REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk("rem_7_m2",    REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0));
      vecs.push_back(mk("divu_5_0",    DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1));
      vecs.push_back(mk("remu_5_0",    REMU, 32'd5, 32'd0, 32'd5, 1'b1));
      vecs.push_back(mk("div_ovf",     DIV, MIN, 32'hFFFF_FFFF, MIN, 1'b1));
      vecs.push_back(mk("rem_ovf",     REM, MIN, 32'hFFFF_FFFF, 32'd0, 1'b1));
      vecs.push_back(mk("div_m5_0",    DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1));
      vecs.push_back(mk("rem_m5_0",    REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1));
      vecs.push_back(mk("divu_min_m1", DIVU, MIN, 32'hFFFF_FFFF, 32'd0, 1'b0));
      vecs.push_back(mk("div_m20_5",   DIV, 32'hFFFF_FFEC, 32'd5, 32'hFFFF_FFFC, 1'b0));
      vecs.push_back(mk("remu_big",    REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0));

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special);

      // Flush an in-flight DIV at its tenth edge; nothing may complete.
      div_opcode = DIV; operand1 = 32'd1000; operand2 = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 2; n <= 9; n++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      expect_no_done("flush_calc", 40);
      run_op("after_flush", DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

      // start together with flush in IDLE is dropped.
      div_opcode = DIVU; operand1 = 32'd40; operand2 = 32'd4; start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      expect_no_done("flush_start", 40);

      // A second start while busy is ignored.
      div_opcode = DIVU; operand1 = 32'd50; operand2 = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 2; n <= 4; n++) tick();
      operand1 = 32'd99; operand2 = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      nd = 0; lat = 0; r = 'x;
      for (int n = 6; n <= 45; n++) begin
         tick();
         if (done_s) begin nd++; lat = n; r = res_s; end
      end
      check("busy_start res", r, 32'd10);
      check("busy_start lat", lat, 32'd34);
      check("busy_start ndone", nd, 32'd1);
      last_res = 32'd10;

      // Asynchronous reset in the middle of an operation.
      div_opcode = DIVU; operand1 = 32'd77; operand2 = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 2; n <= 20; n++) tick();
      #2;
      rst = 1'b0;
      #1;
      check("midrst res_fast", res_f, 32'd0);
      check("midrst res_slow", res_s, 32'd0);
      check("midrst done", {31'd0, done_f | done_s}, 32'd0);
      check("midrst stall", {30'd0, stall_f, stall_s}, 32'd0);
      #10;
      rst = 1'b1;
      last_res = 32'd0;
      expect_no_done("after_rst", 40);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = '1;
            2:       b = 32'($urandom_range(1, 15));
            3: begin a = MIN; b = '1; end
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), op, a, b, ref_div(op, a, b), is_special(op, a, b));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
